// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, handshakes
// with the instruction and data memories, and drives the datapath strobes.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   op_value              current instruction from the IR
//   branch_taken          branch compare result (valid in EXEC)
//   imem_req/imem_ack     instruction fetch handshake; ir_we loads the IR
//   dmem_req/dmem_ack     data access handshake
//   pc_we, pcsrc          PC update strobe and source select
//   alusrc, is_write,     ALU operand select, register write enable,
//   regwritesrc           write-back source select
//   is_access_memory,     data access strobe and store qualifier
//   is_write_memory
//   retire, instret       retire pulse and retired-instruction count
//   halt, trap, bus_err   terminal status flags
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      op_value,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pcsrc,
  output logic             alusrc,
  output logic             is_write,
  output logic             regwritesrc,
  output logic             is_access_memory,
  output logic             is_write_memory,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halt,
  output logic             trap,
  output logic             bus_err
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH,
    CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_SYSTEM
  } class_e;

  state_e             state_q, state_d;
  class_e             class_q, class_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               halt_q, halt_d;
  logic               trap_q, trap_d;
  logic               bus_err_q, bus_err_d;
  logic               timeout_hit;

  // The request has been pending for MEM_TIMEOUT cycles once this cycle ends.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // State, class, counters and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      class_q   <= CL_OPIMM;
      wait_q    <= '0;
      instret_q <= '0;
      halt_q    <= 1'b0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      halt_q    <= halt_d;
      trap_q    <= trap_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d          = state_q;
    class_d          = class_q;
    wait_d           = '0;
    instret_d        = instret_q;
    halt_d           = halt_q;
    trap_d           = trap_q;
    bus_err_d        = bus_err_q;
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pcsrc            = 1'b0;
    alusrc           = 1'b0;
    is_write         = 1'b0;
    regwritesrc      = 1'b0;
    is_access_memory = 1'b0;
    is_write_memory  = 1'b0;
    retire           = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          trap_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
        case (op_value[6:0])
          7'b0110111: class_d = CL_LUI;
          7'b0010111: class_d = CL_AUIPC;
          7'b1101111: class_d = CL_JAL;
          7'b1100111: class_d = CL_JALR;
          7'b1100011: class_d = CL_BRANCH;
          7'b0000011: class_d = CL_LOAD;
          7'b0100011: class_d = CL_STORE;
          7'b0010011: class_d = CL_OPIMM;
          7'b0110011: class_d = CL_OP;
          7'b1110011: class_d = CL_SYSTEM;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end
        endcase
      end

      S_EXEC: begin
        alusrc = !(class_q == CL_OP || class_q == CL_BRANCH);
        case (class_q)
          CL_LOAD, CL_STORE: state_d = S_MEM;
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pcsrc   = branch_taken;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          CL_SYSTEM: begin
            // ECALL is all-zero above the opcode; EBREAK has imm12 == 1.
            if (op_value[31:7] == 25'h0000000 || op_value[31:7] == 25'h0002000) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_HALT;
              halt_d  = 1'b1;
            end else begin
              state_d = S_TRAP;
              trap_d  = 1'b1;
            end
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        dmem_req         = 1'b1;
        is_access_memory = 1'b1;
        is_write_memory  = (class_q == CL_STORE);
        if (dmem_ack) begin
          if (class_q == CL_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          trap_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        is_write    = (op_value[11:7] != 5'd0);
        regwritesrc = (class_q != CL_LOAD);
        pc_we       = 1'b1;
        pcsrc       = (class_q == CL_JAL || class_q == CL_JALR);
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_HALT, S_TRAP: state_d = state_q;

      default: state_d = S_FETCH;
    endcase

    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  assign instret = instret_q;
  assign halt    = halt_q;
  assign trap    = trap_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4).
// Strobe vector order: imem_req dmem_req ir_we pc_we pcsrc alusrc is_write
// regwritesrc is_access_memory is_write_memory retire.
module tb_multicycle_ctrl;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic [31:0]      op_value;
  logic             branch_taken;
  logic             imem_req, imem_ack;
  logic             dmem_req, dmem_ack;
  logic             ir_we, pc_we, pcsrc, alusrc, is_write, regwritesrc;
  logic             is_access_memory, is_write_memory, retire;
  logic [CNT_W-1:0] instret;
  logic             halt, trap, bus_err;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_value(op_value), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pcsrc(pcsrc), .alusrc(alusrc), .is_write(is_write),
    .regwritesrc(regwritesrc), .is_access_memory(is_access_memory),
    .is_write_memory(is_write_memory), .retire(retire), .instret(instret),
    .halt(halt), .trap(trap), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] stb();
    return {imem_req, dmem_req, ir_we, pc_we, pcsrc, alusrc, is_write,
            regwritesrc, is_access_memory, is_write_memory, retire};
  endfunction

  // Apply this cycle's inputs, then settle to mid-cycle for sampling.
  task automatic drv(input logic ia, input logic da, input logic bt);
    imem_ack = ia; dmem_ack = da; branch_taken = bt;
    #3;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] s;
    drv(0, 0, 0);
    s = stb();
    checks++;
    if (s[9:0] !== 10'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000000000", s[9:0]);
    end
    checks++;
    if (instret !== '0) begin
      errors++; $display("FAIL reset_instret: got %0d want 0", instret);
    end
    checks++;
    if ({halt, trap, bus_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {halt, trap, bus_err});
    end
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    logic [10:0] exp [4];
    exp = '{11'b10100000000, 11'b00000000000, 11'b00000100000, 11'b00010011001};
    op_value = 32'h00500093;
    for (int c = 0; c < 4; c++) begin
      drv(c == 0, 0, 0);
      checks++;
      if (stb() !== exp[c]) begin
        errors++; $display("FAIL addi_c%0d: got %b want %b", c + 1, stb(), exp[c]);
      end
      adv();
    end
    checks++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL addi_instret: got %0d want 1", instret);
    end
  endtask

  task automatic test_load_wait();
    logic [10:0] exp [8];
    exp = '{11'b10100000000, 11'b00000000000, 11'b00000100000, 11'b01000000100,
            11'b01000000100, 11'b01000000100, 11'b01000000100, 11'b00010010001};
    op_value = 32'h0000A103;
    for (int c = 0; c < 8; c++) begin
      drv(c == 0, c == 6, 0);
      checks++;
      if (stb() !== exp[c]) begin
        errors++; $display("FAIL lw_c%0d: got %b want %b", c + 1, stb(), exp[c]);
      end
      adv();
    end
    checks++;
    if (instret !== 32'd2) begin
      errors++; $display("FAIL lw_instret: got %0d want 2", instret);
    end
  endtask

  task automatic test_branch();
    logic [10:0] exp;
    op_value = 32'h00208463;
    for (int t = 1; t >= 0; t--) begin
      drv(1, 0, 0); adv();
      drv(0, 0, 0); adv();
      drv(0, 0, t[0]);
      exp = 11'b00010000001 | (11'(t) << 6);
      checks++;
      if (stb() !== exp) begin
        errors++; $display("FAIL beq_taken%0d: got %b want %b", t, stb(), exp);
      end
      adv();
    end
    checks++;
    if (instret !== 32'd4) begin
      errors++; $display("FAIL beq_instret: got %0d want 4", instret);
    end
  endtask

  task automatic test_addi_x0();
    op_value = 32'h00000013;
    drv(1, 0, 0); adv();
    drv(0, 0, 0); adv();
    drv(0, 0, 0); adv();
    drv(0, 0, 0);
    checks++;
    if (stb() !== 11'b00010001001) begin
      errors++; $display("FAIL x0_wb: got %b want 00010001001", stb());
    end
    adv();
    checks++;
    if (instret !== 32'd5) begin
      errors++; $display("FAIL x0_instret: got %0d want 5", instret);
    end
  endtask

  task automatic test_store();
    op_value = 32'h0020A023;
    drv(1, 0, 0); adv();
    drv(0, 0, 0); adv();
    drv(0, 0, 0);
    checks++;
    if (stb() !== 11'b00000100000) begin
      errors++; $display("FAIL sw_exec: got %b want 00000100000", stb());
    end
    adv();
    drv(0, 1, 0);
    checks++;
    if (stb() !== 11'b01010000111) begin
      errors++; $display("FAIL sw_mem: got %b want 01010000111", stb());
    end
    adv();
    checks++;
    if (instret !== 32'd6) begin
      errors++; $display("FAIL sw_instret: got %0d want 6", instret);
    end
  endtask

  task automatic test_reset_mid_mem();
    op_value = 32'h0000A103;
    drv(1, 0, 0); adv();
    drv(0, 0, 0); adv();
    drv(0, 0, 0); adv();
    drv(0, 0, 0);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL midrst_inmem: got %b want 1", dmem_req);
    end
    do_reset();
    checks++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL midrst_instret: got %0d want 0", instret);
    end
    drv(0, 0, 0);
    checks++;
    if (stb() !== 11'b10000000000) begin
      errors++; $display("FAIL midrst_fetch: got %b want 10000000000", stb());
    end
    adv();
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drv(0, 0, 0);
      checks++;
      if (stb() !== 11'b10000000000) begin
        errors++; $display("FAIL tmo_wait_c%0d: got %b want 10000000000", c + 1, stb());
      end
      adv();
    end
    checks++;
    if ({trap, bus_err, halt} !== 3'b110) begin
      errors++; $display("FAIL tmo_flags: got %b want 110", {trap, bus_err, halt});
    end
    drv(1, 0, 0);
    checks++;
    if (stb() !== 11'b0) begin
      errors++; $display("FAIL tmo_quiet: got %b want 00000000000", stb());
    end
    adv();
  endtask

  task automatic test_ack_at_limit_ecall();
    do_reset();
    op_value = 32'h00000073;
    for (int c = 0; c < 3; c++) begin
      drv(0, 0, 0); adv();
    end
    drv(1, 0, 0);
    checks++;
    if (stb() !== 11'b10100000000) begin
      errors++; $display("FAIL limit_ack: got %b want 10100000000", stb());
    end
    adv();
    checks++;
    if (trap !== 1'b0) begin
      errors++; $display("FAIL limit_notrap: got %b want 0", trap);
    end
    drv(0, 0, 0); adv();
    drv(0, 0, 0);
    checks++;
    if (stb() !== 11'b00010100001) begin
      errors++; $display("FAIL ecall_exec: got %b want 00010100001", stb());
    end
    adv();
    checks++;
    if ({halt, trap, instret} !== {2'b10, 32'd1}) begin
      errors++; $display("FAIL ecall_halt: got halt=%b trap=%b instret=%0d want 1 0 1", halt, trap, instret);
    end
    for (int c = 0; c < 3; c++) begin
      drv(1, 1, 0);
      checks++;
      if ({stb(), halt} !== 12'b000000000001) begin
        errors++; $display("FAIL halt_hold_c%0d: got %b want 000000000001", c, {stb(), halt});
      end
      adv();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    op_value = 32'h0000007F;
    drv(1, 0, 0); adv();
    drv(0, 0, 0); adv();
    checks++;
    if ({trap, bus_err, halt} !== 3'b100) begin
      errors++; $display("FAIL illegal_flags: got %b want 100", {trap, bus_err, halt});
    end
    for (int c = 0; c < 3; c++) begin
      drv(1, 0, 0);
      checks++;
      if ({stb(), trap} !== 12'b000000000001) begin
        errors++; $display("FAIL illegal_hold_c%0d: got %b want 000000000001", c, {stb(), trap});
      end
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0; op_value = '0; branch_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_addi_x0();
    test_store();
    test_reset_mid_mem();
    test_fetch_timeout();
    test_ack_at_limit_ecall();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
